// File: rtl/fade_pkg.sv
// Shared level type for the fade generator and PWM output stage.
// Also holds the pending-buffer state encoding used by pwm_fade_out.
package fade_pkg;

    localparam int unsigned LEVEL_W = 10;

    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t PWM_MAX = level_t'((1 << LEVEL_W) - 2);

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } pend_state_e;

endpackage

// File: rtl/pwm_gamma.sv
// Squaring gamma curve: mapped = ((level+1)^2 - 1) >> WIDTH.
// The endpoints are exact: 0 maps to 0, and full scale maps to full scale.
module pwm_gamma
    import fade_pkg::*;
#(
    parameter int unsigned WIDTH = LEVEL_W
) (
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] mapped_o
);

    localparam int unsigned ProdW = 2 * WIDTH + 2;

    logic [ProdW-1:0] lvl_p1;
    logic [ProdW-1:0] sq;

    always_comb begin
        lvl_p1   = ProdW'(level_i) + ProdW'(1);
        sq       = lvl_p1 * lvl_p1 - ProdW'(1);
        mapped_o = WIDTH'(sq >> WIDTH);
    end

endmodule

// File: rtl/pwm_fade_out.sv
// PWM output stage with a double-buffered duty that changes only at period boundaries.
// Define PWM_GAMMA_EN to pass captured levels through the pwm_gamma curve.
module pwm_fade_out
    import fade_pkg::*;
#(
    parameter int unsigned WIDTH    = LEVEL_W,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_level,
    input  logic             i_level_valid,
    output logic             o_level_ready,
    output logic             o_led,
    output logic             o_period_start
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CntMax = WIDTH'((1 << WIDTH) - 2);

    logic [PreW-1:0]  pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             led_q, led_d;
    logic             ps_q, ps_d;
    logic             tick;
    logic             boundary;
    logic             xfer;
    logic [WIDTH-1:0] mapped;

    pend_state_e state_q, state_d;

`ifdef PWM_GAMMA_EN
    pwm_gamma #(
        .WIDTH(WIDTH)
    ) u_gamma (
        .level_i (i_level),
        .mapped_o(mapped)
    );
`else
    assign mapped = i_level;
`endif

    // Pending-buffer state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // A bypass load at a boundary leaves the buffer empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (xfer && !boundary) state_d = StFull;
            StFull:  if (boundary)          state_d = StEmpty;
        endcase
    end

    always_comb begin
        o_level_ready = (state_q == StEmpty);
    end

    always_comb begin
        tick     = (pre_q == PreW'(PRESCALE - 1));
        pre_d    = tick ? '0 : pre_q + PreW'(1);
        boundary = tick && (cnt_q == CntMax);
        if (!tick) begin
            cnt_d = cnt_q;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        xfer   = i_level_valid && o_level_ready;
        duty_d = duty_q;
        pend_d = pend_q;
        if (boundary && (state_q == StFull)) begin
            duty_d = pend_q;
        end else if (boundary && xfer) begin
            duty_d = mapped;
        end else if (xfer) begin
            pend_d = mapped;
        end

        led_d = (cnt_q < duty_q);
        ps_d  = boundary;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            duty_q <= '0;
            pend_q <= '0;
            led_q  <= 1'b0;
            ps_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pend_q <= pend_d;
            led_q  <= led_d;
            ps_q   <= ps_d;
        end
    end

    assign o_led          = led_q;
    assign o_period_start = ps_q;

endmodule

// File: tb/tb_pwm_fade_out.sv
// Bench for pwm_fade_out: directed scenarios plus random levels, checked every cycle
// against a period-arithmetic reference model for a PRESCALE=1 and a PRESCALE=3 instance.
module tb_pwm_fade_out;

    localparam int W   = 10;
    localparam int PER = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] level;
    logic         valid;
    logic         rdy0, led0, ps0;
    logic         rdy1, led1, ps1;

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance: cycles since reset, duty, pending buffer
    int m_n[2];
    int m_duty[2];
    int m_pend[2];
    bit m_full[2];
    bit m_led[2];
    bit m_ps[2];
    bit m_acc[2];

    pwm_fade_out #(
        .WIDTH   (W),
        .PRESCALE(1)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_level       (level),
        .i_level_valid (valid),
        .o_level_ready (rdy0),
        .o_led         (led0),
        .o_period_start(ps0)
    );

    pwm_fade_out #(
        .WIDTH   (W),
        .PRESCALE(3)
    ) u_dut_p3 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_level       (level),
        .i_level_valid (valid),
        .o_level_ready (rdy1),
        .o_led         (led1),
        .o_period_start(ps1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gmap(input int l);
`ifdef PWM_GAMMA_EN
        return ((l + 1) * (l + 1) - 1) >> W;
`else
        return l;
`endif
    endfunction

    function automatic int presc(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k);
        int p, c;
        bit tk, bnd, xf;
        if (!rst_n) begin
            m_n[k]    = 0;
            m_duty[k] = 0;
            m_pend[k] = 0;
            m_full[k] = 0;
            m_led[k]  = 0;
            m_ps[k]   = 0;
            m_acc[k]  = 0;
        end else begin
            p   = presc(k);
            c   = (m_n[k] / p) % PER;
            tk  = (m_n[k] % p) == p - 1;
            bnd = tk && (c == PER - 1);
            xf  = valid && !m_full[k];
            m_acc[k] = xf;
            m_led[k] = c < m_duty[k];
            m_ps[k]  = bnd;
            if (bnd && m_full[k]) begin
                m_duty[k] = m_pend[k];
                m_full[k] = 0;
            end else if (bnd && xf) begin
                m_duty[k] = gmap(int'(level));
            end else if (xf) begin
                m_pend[k] = gmap(int'(level));
                m_full[k] = 1;
            end
            m_n[k]++;
        end
    endtask

    // One clock: advance the model on the current inputs, then compare all outputs
    task automatic step();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        chk("led_p1", 32'(led0), 32'(m_led[0]));
        chk("ps_p1", 32'(ps0), 32'(m_ps[0]));
        chk("rdy_p1", 32'(rdy0), 32'(!m_full[0]));
        chk("led_p3", 32'(led1), 32'(m_led[1]));
        chk("ps_p3", 32'(ps1), 32'(m_ps[1]));
        chk("rdy_p3", 32'(rdy1), 32'(!m_full[1]));
    endtask

    task automatic send(input int lvl, output int waited);
        valid  = 1'b1;
        level  = W'(lvl);
        waited = 0;
        forever begin
            step();
            waited++;
            if (m_acc[0]) break;
            if (waited > 5000) begin
                chk("send_timeout", 32'(0), 32'(1));
                break;
            end
        end
        valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n;
        n = 0;
        while (!m_ps[0]) begin
            step();
            n++;
            if (n > 5000) begin
                chk("ps_timeout", 32'(0), 32'(1));
                break;
            end
        end
    endtask

    task automatic measure(input int cycles, output int highs, output int pss);
        highs = 0;
        pss   = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            highs += int'(led0);
            pss   += int'(ps0);
        end
    endtask

    initial begin
        int w, h, p, n;
        rst_n = 1'b0;
        valid = 1'b0;
        level = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_led", 32'(led0), 32'(0));
        chk("rst_ps", 32'(ps0), 32'(0));
        chk("rst_rdy", 32'(rdy0), 32'(1));
        chk("rst_led_p3", 32'(led1), 32'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Half-scale level: high time and period length
        send(512, w);
        wait_ps();
        measure(PER, h, p);
        chk("t1_high", 32'(h), 32'(gmap(512)));
        chk("t1_ps_count", 32'(p), 32'(1));
        measure(PER, h, p);
        chk("t1_high_again", 32'(h), 32'(gmap(512)));
        chk("t1_ps_again", 32'(p), 32'(1));

        // Full scale is constant high, zero is constant low
        send(PER, w);
        wait_ps();
        measure(3 * PER, h, p);
        chk("t2_full_high", 32'(h), 32'(3 * PER));
        chk("t2_full_ps", 32'(p), 32'(3));
        send(0, w);
        wait_ps();
        measure(3 * PER, h, p);
        chk("t2_zero_high", 32'(h), 32'(0));

        // Two levels inside one period: second waits for the boundary
        wait_ps();
        for (int i = 0; i < 10; i++) step();
        send(300, w);
        chk("t3_first_wait", 32'(w), 32'(1));
        valid = 1'b1;
        level = W'(700);
        step();
        chk("t3_ready_low", 32'(rdy0), 32'(0));
        send(700, w);
        measure(PER - 1, h, p);
        chk("t3_high_300", 32'(h), 32'(gmap(300) - 1));
        chk("t3_ps", 32'(p), 32'(1));
        measure(PER, h, p);
        chk("t3_high_700", 32'(h), 32'(gmap(700)));

        // Transfer on the boundary cycle with an empty buffer bypasses into duty
        n = 0;
        while ((m_n[0] % PER) != PER - 1 && n < 5000) begin
            step();
            n++;
        end
        valid = 1'b1;
        level = W'(100);
        step();
        valid = 1'b0;
        chk("t4_ps", 32'(ps0), 32'(1));
        chk("t4_rdy", 32'(rdy0), 32'(1));
        measure(PER, h, p);
        chk("t4_high_100", 32'(h), 32'(gmap(100)));

        // Reset mid-period
        send(800, w);
        wait_ps();
        for (int i = 0; i < 200; i++) step();
        chk("t5_led_before", 32'(led0), 32'(1));
        rst_n = 1'b0;
        step();
        chk("t5_led", 32'(led0), 32'(0));
        chk("t5_rdy", 32'(rdy0), 32'(1));
        chk("t5_ps", 32'(ps0), 32'(0));
        rst_n = 1'b1;
        measure(2100, h, p);
        chk("t5_high_after", 32'(h), 32'(0));
        chk("t5_ps_after", 32'(p), 32'(2));

        // Random levels with random gaps
        for (int t = 0; t < 20; t++) begin
            int gap, lvl, sel;
            gap = int'($urandom_range(0, 700));
            for (int i = 0; i < gap; i++) step();
            sel = int'($urandom_range(0, 7));
            if (sel == 0) lvl = 0;
            else if (sel == 1) lvl = PER;
            else lvl = int'($urandom_range(0, PER));
            send(lvl, w);
        end
        for (int i = 0; i < 2 * PER; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_fade_out.md
Name: pwm_fade_out

Overview:
Output stage downstream of the smooth-fade cycle generator. It takes the generator's 10-bit brightness level through a valid/ready handshake and turns it into a PWM waveform on the LED pin. The duty value is double-buffered and only changes at a PWM period boundary, so there are no mid-period glitches. An optional gamma curve makes the fade look perceptually linear.

Parameters:
WIDTH, 10, level/duty bit width; PWM period = 2^WIDTH-1 ticks
PRESCALE, 1, clocks per PWM tick (>=1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous reset, active low
i_level  in  WIDTH  brightness level from fade generator (0..2^WIDTH-1)
i_level_valid  in  1  i_level is valid this cycle
o_level_ready  out  1  stage can accept a level
o_led  out  1  PWM output to LED
o_period_start  out  1  one-clock pulse at each PWM period start

Behaviour:
- Interface: one clock (i_clk); reset i_rst_n is synchronous, active-low; all state updates on rising i_clk.
- Reset values:
  - prescaler 0, tick counter cnt 0, active duty 0, pending empty
  - o_led 0, o_period_start 0, o_level_ready 1
- Prescaler:
  - Counts 0..PRESCALE-1; tick is asserted when prescaler == PRESCALE-1.
  - PRESCALE=1 gives a tick every clock.
- cnt:
  - Advances on tick, range 0..2^WIDTH-2, wraps to 0.
  - A boundary is a tick where cnt == 2^WIDTH-2.
- o_period_start: registered; high for one clock in the cycle after a boundary, i.e. when cnt first shows 0.
- o_led:
  - Registered: o_led <= (cnt < duty), one-clock latency.
  - duty 0 gives a constant 0; duty 2^WIDTH-1 gives a constant 1.
- Handshake:
  - Transfer occurs when i_level_valid && o_level_ready.
  - o_level_ready = !pending_full, registered.
  - A transfer stores the (optionally gamma-mapped) value in pending and sets pending_full.
- Boundary:
  - If pending_full: duty <= pending, pending_full cleared; ready returns high next cycle.
  - If pending empty and a transfer occurs in the same cycle: the value loads directly into duty (bypass); pending stays empty.
  - If neither: duty holds.
- A level is never dropped. A level presented while not ready is held by the producer.
- Reset mid-period: all state returns to reset values on the next edge; o_led goes 0 the cycle after reset is sampled.
- Duty 2^WIDTH-1 compares against cnt max 2^WIDTH-2, so the LED is always on.

Optional Feature:
PWM_GAMMA_EN
- Defined:
  - mapped = ((level+1)^2 - 1) >> WIDTH, computed on i_level at capture in 2*WIDTH+2-bit arithmetic.
  - Maps 0->0, 2^WIDTH-1 -> 2^WIDTH-1, 512 -> 257 (WIDTH=10).
- Undefined: mapped = level unchanged; no multiplier is inferred.

Decomposition:
- Shared package fade_pkg:
  - LEVEL_W=10, level_t (logic [LEVEL_W-1:0])
  - PWM_MAX = 2^LEVEL_W-2
  - This is the same level type used by the fade cycle generator.
- Sub-module pwm_gamma: combinational level_t -> level_t mapping, instantiated only under PWM_GAMMA_EN.

Test Plan:
1. Reset, then level 512 (PRESCALE=1, WIDTH=10) -> after the first boundary, o_led high exactly 512 of every 1023 clocks; o_period_start pulses every 1023 clocks.
2. Levels 0 and 1023 -> o_led constant 0 / constant 1 across 3 full periods, with no single-cycle glitch at the wrap.
3. Send 300 then 700 within one period -> 300 accepted, o_level_ready low until the boundary; 700 accepted the cycle ready returns; duty 300 then 700 in successive periods.
4. Handshake on the boundary cycle with pending empty, level 100 -> the next period's high time is 100 clocks (bypass, no extra period of latency).
5. Assert i_rst_n=0 for 1 clock mid-period with duty 800 -> o_led 0, o_level_ready 1, cnt restarts at 0; the subsequent output is 0 until a new level loads.
6. PWM_GAMMA_EN, level 512 -> high time 257 clocks; level 1023 -> constant high; PRESCALE=4 -> period 4092 clocks.
